mcu_spi_slave: RTL and testbench

MCU_SPI_SLAVE -- requirements
Module: mcu_spi_slave

---
 rtl/mcu_spi_slave_pkg.sv | 25 ++
 rtl/mcu_spi_slave_pin_sync.sv | 37 +++
 rtl/mcu_spi_slave.sv | 199 +++++++++++++++++++
 tb/tb_mcu_spi_slave.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_spi_slave_pkg.sv
// Shared constants and helpers for the MCU SPI slave.
package mcu_spi_slave_pkg;

  // Number of flops in each pin synchroniser.
  localparam int unsigned SYNC_DEPTH         = 32'd3;
  // Transmit shifter contents and MISO level while idle or in reset.
  localparam logic [7:0]  TX_SHIFT_RST       = 8'hFF;
  localparam logic        MISO_RST           = 1'b1;
  // Default idle-timeout length in clk cycles.
  localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd65535;
  // Upper limit of the byte counter.
  localparam logic [31:0] BYTE_CNT_MAX       = 32'hFFFF_FFFF;

  // Increment that sticks at the maximum instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == BYTE_CNT_MAX) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mcu_spi_slave_pin_sync.sv
// Multi-flop synchroniser for one raw SPI pin, with edge strobes taken
// from the two oldest stages so the level and edges are mutually aligned.
module spi_pin_sync
  import mcu_spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [SYNC_DEPTH-1:0] sync_d;

  // Shift the raw pin into the youngest stage.
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], pin_i};
  end

  // Synchroniser flops, reset to the pin's idle level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {SYNC_DEPTH{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level_o = sync_q[SYNC_DEPTH-2];
  assign rise_o  = sync_q[SYNC_DEPTH-2] & ~sync_q[SYNC_DEPTH-1];
  assign fall_o  = ~sync_q[SYNC_DEPTH-2] & sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/mcu_spi_slave.sv
// Mode-0 SPI slave for an MCU host: oversamples SCK/MOSI/SSEL_N in the clk
// domain, splits each frame into a command byte followed by parameter bytes,
// and shifts decoder-supplied bytes out on MISO.
// Optional feature: define MCU_SPI_IDLE_TIMEOUT_EN to resync the bit counter
// after TIMEOUT_CYCLES clk cycles without an SCK edge while selected.
module mcu_spi_slave
  import mcu_spi_slave_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        mosi,
  input  logic        ssel_n,
  output logic        miso,
  output logic        cmd_ready,
  output logic        param_ready,
  output logic [7:0]  cmd_data,
  output logic [7:0]  param_data,
  output logic [31:0] spi_byte_cnt,
  output logic [2:0]  spi_bit_cnt,
  input  logic [7:0]  spi_data_out,
  output logic        timeout_flag
);

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES - 32'd1);

  logic sck_lvl_s, sck_rise_s, sck_fall_s;
  logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
  logic ssel_lvl_s, ssel_rise_s, ssel_fall_s;
  logic unused_s;

  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic        byte_done_q, byte_done_d;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic [7:0]  param_data_q, param_data_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        param_ready_q, param_ready_d;
  logic        miso_q, miso_d;
`ifdef MCU_SPI_IDLE_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk_i(clk), .rst_n_i(rst_n), .pin_i(sck),
    .level_o(sck_lvl_s), .rise_o(sck_rise_s), .fall_o(sck_fall_s)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk), .rst_n_i(rst_n), .pin_i(mosi),
    .level_o(mosi_lvl_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s)
  );

  spi_pin_sync #(.RST_VAL(1'b1)) u_sync_ssel (
    .clk_i(clk), .rst_n_i(rst_n), .pin_i(ssel_n),
    .level_o(ssel_lvl_s), .rise_o(ssel_rise_s), .fall_o(ssel_fall_s)
  );

  assign unused_s = ^{sck_lvl_s, mosi_rise_s, mosi_fall_s, TO_LIMIT};

  // Next-state logic: deselect wins over select, which wins over SCK activity.
  always_comb begin
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_done_d   = 1'b0;
    cmd_data_d    = cmd_data_q;
    param_data_d  = param_data_q;
    cmd_ready_d   = 1'b0;
    param_ready_d = 1'b0;
    miso_d        = miso_q;
`ifdef MCU_SPI_IDLE_TIMEOUT_EN
    idle_cnt_d    = idle_cnt_q;
    timeout_d     = timeout_q;
`endif

    if (ssel_rise_s) begin
      // Frame ends: any partial byte is dropped without a strobe.
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
      tx_shift_d = TX_SHIFT_RST;
      miso_d     = MISO_RST;
    end else if (ssel_fall_s) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 32'd0;
      rx_shift_d = 8'h00;
      tx_shift_d = spi_data_out;
      miso_d     = spi_data_out[7];
`ifdef MCU_SPI_IDLE_TIMEOUT_EN
      timeout_d  = 1'b0;
`endif
    end else if (!ssel_lvl_s) begin
      if (byte_done_q) begin
        // First byte of a frame is the command, the rest are parameters.
        byte_cnt_d = sat_inc32(byte_cnt_q);
        if (byte_cnt_q == 32'd0) begin
          cmd_data_d  = rx_shift_q;
          cmd_ready_d = 1'b1;
        end else begin
          param_data_d  = rx_shift_q;
          param_ready_d = 1'b1;
        end
        tx_shift_d = spi_data_out;
        miso_d     = spi_data_out[7];
      end else begin
        byte_cnt_d = byte_cnt_q;
      end

      if (sck_rise_s) begin
        rx_shift_d  = {rx_shift_q[6:0], mosi_lvl_s};
        bit_cnt_d   = bit_cnt_q + 3'd1;
        byte_done_d = (bit_cnt_q == 3'd7);
      end else if (sck_fall_s) begin
        // The falling edge after bit 7 must not shift away the fresh MSB.
        if (bit_cnt_q != 3'd0) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b1};
          miso_d     = tx_shift_q[6];
        end else begin
          miso_d     = tx_shift_d[7];
        end
      end else begin
        byte_done_d = 1'b0;
      end
    end else begin
      miso_d = MISO_RST;
    end

`ifdef MCU_SPI_IDLE_TIMEOUT_EN
    // Idle watchdog: resync the bit position after a long SCK silence.
    if (!ssel_lvl_s && !ssel_fall_s && !sck_rise_s && !sck_fall_s) begin
      if (idle_cnt_q == TO_LIMIT) begin
        idle_cnt_d = 32'd0;
        bit_cnt_d  = 3'd0;
        rx_shift_d = 8'h00;
        timeout_d  = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 32'd1;
      end
    end else begin
      idle_cnt_d = 32'd0;
    end
`endif
  end

  // State registers with asynchronous reset to the idle frame state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift_q    <= 8'h00;
      tx_shift_q    <= TX_SHIFT_RST;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 32'd0;
      byte_done_q   <= 1'b0;
      cmd_data_q    <= 8'h00;
      param_data_q  <= 8'h00;
      cmd_ready_q   <= 1'b0;
      param_ready_q <= 1'b0;
      miso_q        <= MISO_RST;
`ifdef MCU_SPI_IDLE_TIMEOUT_EN
      idle_cnt_q    <= 32'd0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_done_q   <= byte_done_d;
      cmd_data_q    <= cmd_data_d;
      param_data_q  <= param_data_d;
      cmd_ready_q   <= cmd_ready_d;
      param_ready_q <= param_ready_d;
      miso_q        <= miso_d;
`ifdef MCU_SPI_IDLE_TIMEOUT_EN
      idle_cnt_q    <= idle_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign miso         = miso_q;
  assign cmd_ready    = cmd_ready_q;
  assign param_ready  = param_ready_q;
  assign cmd_data     = cmd_data_q;
  assign param_data   = param_data_q;
  assign spi_byte_cnt = byte_cnt_q;
  assign spi_bit_cnt  = bit_cnt_q;
`ifdef MCU_SPI_IDLE_TIMEOUT_EN
  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Self-checking bench for mcu_spi_slave: drives SPI frames as an MCU host and
// compares strobes, captured bytes and MISO data with a frame-level model.
module tb_mcu_spi_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck, mosi, ssel_n;
  logic [7:0]  spi_data_out;
  logic        miso, cmd_ready, param_ready, timeout_flag;
  logic [7:0]  cmd_data, param_data;
  logic [31:0] spi_byte_cnt;
  logic [2:0]  spi_bit_cnt;

  int checks = 0;
  int errors = 0;

  // Frame-level model state: last command and parameter bytes seen.
  logic [7:0] model_cmd   = 8'h00;
  logic [7:0] model_param = 8'h00;

  typedef struct packed {
    logic        is_cmd;
    logic [7:0]  data;
    logic [31:0] cnt;
  } ev_t;
  ev_t ev_q[$];

  always #5 clk = ~clk;

  mcu_spi_slave #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .ssel_n(ssel_n),
    .miso(miso), .cmd_ready(cmd_ready), .param_ready(param_ready),
    .cmd_data(cmd_data), .param_data(param_data),
    .spi_byte_cnt(spi_byte_cnt), .spi_bit_cnt(spi_bit_cnt),
    .spi_data_out(spi_data_out), .timeout_flag(timeout_flag)
  );

  // Record every byte strobe with the data and count visible alongside it.
  always @(negedge clk) begin
    if (cmd_ready)   ev_q.push_back({1'b1, cmd_data, spi_byte_cnt});
    if (param_ready) ev_q.push_back({1'b0, param_data, spi_byte_cnt});
  end

  task automatic frame_begin(input logic [7:0] tx0);
    @(negedge clk);
    spi_data_out = tx0;
    ssel_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    ssel_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Send the top n bits of mo MSB first; next_tx is offered before bit 7.
  task automatic spi_bits(input logic [7:0] mo, input int n,
                          input logic [7:0] next_tx, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      @(negedge clk);
      mosi = mo[i];
      if (i == 0) spi_data_out = next_tx;
      repeat (HALF) @(negedge clk);
      mi[i] = miso;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if ({miso, cmd_ready, param_ready, timeout_flag} !== 4'b1000) begin errors++; $display("FAIL reset_bits got %b exp 1000", {miso, cmd_ready, param_ready, timeout_flag}); end
    checks++; if (cmd_data !== 8'h00) begin errors++; $display("FAIL reset_cmd got %h exp 00", cmd_data); end
    checks++; if (param_data !== 8'h00) begin errors++; $display("FAIL reset_param got %h exp 00", param_data); end
    checks++; if (spi_byte_cnt !== 32'd0) begin errors++; $display("FAIL reset_bytecnt got %0d exp 0", spi_byte_cnt); end
    checks++; if (spi_bit_cnt !== 3'd0) begin errors++; $display("FAIL reset_bitcnt got %0d exp 0", spi_bit_cnt); end
  endtask

  task automatic test_basic();
    logic [7:0] mi;
    int base;
    base = ev_q.size();
    frame_begin(8'h00);
    spi_bits(8'h91, 8, 8'h00, mi);
    spi_bits(8'h5A, 8, 8'h00, mi);
    frame_end();
    model_cmd = 8'h91; model_param = 8'h5A;
    checks++; if (ev_q.size() !== base + 2) begin errors++; $display("FAIL basic_count got %0d exp %0d", ev_q.size() - base, 2); end
    if (ev_q.size() >= base + 2) begin
      checks++; if (ev_q[base] !== {1'b1, 8'h91, 32'd1}) begin errors++; $display("FAIL basic_cmd got %h exp %h", ev_q[base], {1'b1, 8'h91, 32'd1}); end
      checks++; if (ev_q[base+1] !== {1'b0, 8'h5A, 32'd2}) begin errors++; $display("FAIL basic_param got %h exp %h", ev_q[base+1], {1'b0, 8'h5A, 32'd2}); end
    end
  endtask

  task automatic test_miso();
    logic [7:0] mi0, mi1, b0, b1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    frame_begin(8'hA5);
    spi_bits(b0, 8, 8'h3C, mi0);
    spi_bits(b1, 8, 8'hFF, mi1);
    frame_end();
    model_cmd = b0; model_param = b1;
    checks++; if (mi0 !== 8'hA5) begin errors++; $display("FAIL miso_byte0 got %h exp a5", mi0); end
    checks++; if (mi1 !== 8'h3C) begin errors++; $display("FAIL miso_byte1 got %h exp 3c", mi1); end
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL miso_idle got %b exp 1", miso); end
  endtask

  task automatic test_random_frames();
    logic [7:0] b[4];
    logic [7:0] tx[5];
    logic [7:0] mi;
    int len, base;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < 5; j++) tx[j] = 8'($urandom);
      for (int j = 0; j < 4; j++) b[j] = 8'($urandom);
      base = ev_q.size();
      frame_begin(tx[0]);
      for (int j = 0; j < len; j++) begin
        spi_bits(b[j], 8, tx[j+1], mi);
        checks++; if (mi !== tx[j]) begin errors++; $display("FAIL rand_miso f%0d b%0d got %h exp %h", f, j, mi, tx[j]); end
      end
      frame_end();
      model_cmd = b[0];
      if (len > 1) model_param = b[len-1];
      checks++; if (ev_q.size() !== base + len) begin errors++; $display("FAIL rand_count f%0d got %0d exp %0d", f, ev_q.size() - base, len); end
      for (int j = 0; j < len && base + j < ev_q.size(); j++) begin
        checks++; if (ev_q[base+j] !== {(j == 0), b[j], 32'(j + 1)}) begin errors++; $display("FAIL rand_event f%0d b%0d got %h exp %h", f, j, ev_q[base+j], {(j == 0), b[j], 32'(j + 1)}); end
      end
      checks++; if (cmd_data !== model_cmd) begin errors++; $display("FAIL rand_cmd_hold f%0d got %h exp %h", f, cmd_data, model_cmd); end
      checks++; if (param_data !== model_param) begin errors++; $display("FAIL rand_param_hold f%0d got %h exp %h", f, param_data, model_param); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int base;
    base = ev_q.size();
    frame_begin(8'h00);
    spi_bits(8'hC3, 8, 8'h00, mi);
    spi_bits(8'hFF, 5, 8'h00, mi);
    repeat (2) @(negedge clk);
    checks++; if (spi_bit_cnt !== 3'd5) begin errors++; $display("FAIL abort_bits5 got %0d exp 5", spi_bit_cnt); end
    ssel_n = 1'b1;
    repeat (HALF) @(negedge clk);
    model_cmd = 8'hC3;
    checks++; if (ev_q.size() !== base + 1) begin errors++; $display("FAIL abort_strobes got %0d exp 1", ev_q.size() - base); end
    checks++; if (spi_bit_cnt !== 3'd0) begin errors++; $display("FAIL abort_bitcnt got %0d exp 0", spi_bit_cnt); end
    checks++; if (param_data !== model_param) begin errors++; $display("FAIL abort_param got %h exp %h", param_data, model_param); end
    checks++; if (cmd_data !== model_cmd) begin errors++; $display("FAIL abort_cmd got %h exp %h", cmd_data, model_cmd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    int base;
    frame_begin(8'h00);
    spi_bits(8'h11, 8, 8'h00, mi);
    spi_bits(8'h22, 8, 8'h00, mi);
    spi_bits(8'h33, 3, 8'h00, mi);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_cmd = 8'h00; model_param = 8'h00;
    test_reset();
    ssel_n = 1'b1; mosi = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    base = ev_q.size();
    frame_begin(8'h00);
    spi_bits(8'h4D, 8, 8'h00, mi);
    frame_end();
    model_cmd = 8'h4D;
    checks++; if (ev_q.size() !== base + 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", ev_q.size() - base); end
    if (ev_q.size() >= base + 1) begin
      checks++; if (ev_q[base] !== {1'b1, 8'h4D, 32'd1}) begin errors++; $display("FAIL rstmid_cmd got %h exp %h", ev_q[base], {1'b1, 8'h4D, 32'd1}); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] mi;
    int base;
    base = ev_q.size();
    frame_begin(8'h00);
    spi_bits(8'hE0, 3, 8'h00, mi);
    repeat (24) @(negedge clk);
`ifdef MCU_SPI_IDLE_TIMEOUT_EN
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", timeout_flag); end
    checks++; if (spi_bit_cnt !== 3'd0) begin errors++; $display("FAIL timeout_bitcnt got %0d exp 0", spi_bit_cnt); end
    spi_bits(8'h6B, 8, 8'h00, mi);
    frame_end();
    model_cmd = 8'h6B;
    checks++; if (ev_q.size() !== base + 1) begin errors++; $display("FAIL timeout_count got %0d exp 1", ev_q.size() - base); end
    if (ev_q.size() >= base + 1) begin
      checks++; if (ev_q[base] !== {1'b1, 8'h6B, 32'd1}) begin errors++; $display("FAIL timeout_byte got %h exp %h", ev_q[base], {1'b1, 8'h6B, 32'd1}); end
    end
    frame_begin(8'h00);
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", timeout_flag); end
    frame_end();
`else
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL timeout_off_flag got %b exp 0", timeout_flag); end
    checks++; if (spi_bit_cnt !== 3'd3) begin errors++; $display("FAIL timeout_off_bitcnt got %0d exp 3", spi_bit_cnt); end
    frame_end();
    checks++; if (ev_q.size() !== base) begin errors++; $display("FAIL timeout_off_strobes got %0d exp 0", ev_q.size() - base); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; ssel_n = 1'b1; spi_data_out = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    test_basic();
    test_miso();
    test_random_frames();
    test_abort();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
